// File: rtl/alu_div_seq.sv
// Multicycle restoring divider: one quotient bit per cycle, signed or unsigned,
// with a zero-divisor shortcut and registered quotient/remainder/flag outputs.
module alu_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [2:0]       dbg_state
);

  // Handshake: start is only sampled in IDLE; busy stays high from the edge that
  // accepts start through the single done cycle, and results are valid while done is high.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] pr_q, pr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   pr_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  // a_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  // The stored partial remainder is always below the divisor, so WIDTH bits hold it;
  // the extra bit exists only in the shifted/trial values.
  always_comb begin
    state_d  = state_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    sgn_d    = sgn_q;
    a_d      = a_q;
    b_d      = b_q;
    pr_d     = pr_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    done_d   = done_q;
    pr_shift = {pr_q, a_q[WIDTH-1]};
    trial    = pr_shift - {1'b0, b_q};
    q_fix    = (sgn_q && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1])) ? -a_q : a_q;
    r_fix    = (sgn_q && dvd_q[WIDTH-1]) ? -pr_q : pr_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          sgn_d   = is_signed;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (dvs_q == '0) begin
          quo_d   = '1;
          rem_d   = dvd_q;
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          a_d     = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
          b_d     = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
          pr_d    = '0;
          cnt_d   = CW'(WIDTH - 1);
          dbz_d   = 1'b0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (!trial[WIDTH]) begin
          pr_d = trial[WIDTH-1:0];
          a_d  = {a_q[WIDTH-2:0], 1'b1};
        end else begin
          pr_d = pr_shift[WIDTH-1:0];
          a_d  = {a_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        quo_d   = q_fix;
        rem_d   = r_fix;
        state_d = S_DONE;
      end
      S_DONE: begin
        // First DONE cycle raises done; the second returns to IDLE.
        if (!done_q) begin
          done_d = 1'b1;
        end else begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = done_q;
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
    dbg_state   = state_q;
  end

endmodule
